// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver / path checker pair:
// move encodings, error codes and the checker state enumeration.
package maze_pkg;

  localparam logic [1:0] MV_UP    = 2'b00;
  localparam logic [1:0] MV_RIGHT = 2'b01;
  localparam logic [1:0] MV_LEFT  = 2'b10;
  localparam logic [1:0] MV_DOWN  = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_WALL  = 2'b10;
  localparam logic [1:0] ERR_END   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CALC  = 3'd2,
    ST_PROBE = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5,
    ST_FAIL  = 3'd6
  } state_t;

endpackage

// File: rtl/maze_coord_step.sv
// Combinational single-step coordinate update; leaving the grid on either
// edge shows up as a carry/borrow into the extra top bit.
module maze_coord_step
  import maze_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [1:0]   move,
  output logic [W-1:0] nx,
  output logic [W-1:0] ny,
  output logic         out_of_range
);

  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  logic [W:0] wx_s;
  logic [W:0] wy_s;

  // Widened next-coordinate arithmetic
  always_comb begin
    wx_s = {1'b0, x};
    wy_s = {1'b0, y};
    case (move)
      MV_UP:    wy_s = {1'b0, y} - ONE;
      MV_RIGHT: wx_s = {1'b0, x} + ONE;
      MV_LEFT:  wx_s = {1'b0, x} - ONE;
      MV_DOWN:  wy_s = {1'b0, y} + ONE;
      default: begin
        wx_s = {1'b0, x};
        wy_s = {1'b0, y};
      end
    endcase
  end

  assign nx           = wx_s[W-1:0];
  assign ny           = wy_s[W-1:0];
  assign out_of_range = wx_s[W] | wy_s[W];

endmodule

// File: rtl/maze_path_checker.sv
// Replays a move stream from (0,0) against the maze memory and reports
// whether it reaches the goal cell, or why it was rejected.
module maze_path_checker
  import maze_pkg::*;
#(
  parameter int            W      = 4,
  parameter int            STEP_W = 8,
  parameter logic [W-1:0]  GOAL_X = {W{1'b1}},
  parameter logic [W-1:0]  GOAL_Y = {W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              move_valid,
  input  logic [1:0]        move,
  output logic              move_ready,
  input  logic              path_end,
  output logic              mem_rd,
  output logic [2*W-1:0]    mem_addr,
  input  logic              mem_dout,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [1:0]        err_code,
  output logic [W-1:0]      x_o,
  output logic [W-1:0]      y_o,
  output logic [STEP_W-1:0] step_cnt
);

  state_t              state_r;
  logic [1:0]          mv_r;
  logic [W-1:0]        x_r, y_r, nx_r, ny_r;
  logic [STEP_W-1:0]   step_r;
  logic                ready_r, rd_r, busy_r, done_r, fail_r;
  logic [2*W-1:0]      addr_r;
  logic [1:0]          err_r;
  logic [W-1:0]        nx_s, ny_s;
  logic                oor_s;

  maze_coord_step #(.W(W)) u_step (
    .x            (x_r),
    .y            (y_r),
    .move         (mv_r),
    .nx           (nx_s),
    .ny           (ny_s),
    .out_of_range (oor_s)
  );

  // Checker FSM; all outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      mv_r    <= MV_UP;
      x_r     <= '0;
      y_r     <= '0;
      nx_r    <= '0;
      ny_r    <= '0;
      step_r  <= '0;
      ready_r <= 1'b0;
      rd_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fail_r  <= 1'b0;
      addr_r  <= '0;
      err_r   <= ERR_NONE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            x_r     <= '0;
            y_r     <= '0;
            step_r  <= '0;
            done_r  <= 1'b0;
            fail_r  <= 1'b0;
            err_r   <= ERR_NONE;
            ready_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A move presented together with path_end takes priority
          if (move_valid) begin
            mv_r    <= move;
            ready_r <= 1'b0;
            state_r <= ST_CALC;
          end else if (path_end) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            fail_r  <= 1'b1;
            err_r   <= ERR_END;
            state_r <= ST_FAIL;
          end
        end
        ST_CALC: begin
          if (oor_s) begin
            busy_r  <= 1'b0;
            fail_r  <= 1'b1;
            err_r   <= ERR_RANGE;
            state_r <= ST_FAIL;
          end else begin
            nx_r    <= nx_s;
            ny_r    <= ny_s;
            rd_r    <= 1'b1;
            addr_r  <= {ny_s, nx_s};
            state_r <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          rd_r    <= 1'b0;
          state_r <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mem_dout) begin
            busy_r  <= 1'b0;
            fail_r  <= 1'b1;
            err_r   <= ERR_WALL;
            state_r <= ST_FAIL;
          end else begin
            x_r    <= nx_r;
            y_r    <= ny_r;
            step_r <= (&step_r) ? step_r : step_r + STEP_W'(1);
            if ((nx_r == GOAL_X) && (ny_r == GOAL_Y)) begin
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              ready_r <= 1'b1;
              state_r <= ST_WAIT;
            end
          end
        end
        default: begin
          ready_r <= 1'b0;
          rd_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign move_ready = ready_r;
  assign mem_rd     = rd_r;
  assign mem_addr   = addr_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fail       = fail_r;
  assign err_code   = err_r;
  assign x_o        = x_r;
  assign y_o        = y_r;
  assign step_cnt   = step_r;

endmodule

// File: doc/maze_path_checker.md
Name: maze_path_checker

Overview:
- Consumer end of the rat-in-maze move stream: accepts 2-bit moves one at a time over a valid/ready handshake.
- Replays each move from the start cell, checks it against the same maze memory (range and wall) and tracks position and step count.
- Declares success when the goal cell is reached, or failure with a reason code; used as the self-check partner for the solver.

Parameters:
- W, 4, coordinate width; maze is 2^W x 2^W cells
- STEP_W, 8, step counter width; saturates at all-ones
- GOAL_X, 2^W-1, goal column
- GOAL_Y, 2^W-1, goal row

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a check at (0,0); honoured only in IDLE, DONE or FAIL
- move_valid  input  1  move is presented on move
- move  input  2  00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1)
- move_ready  output  1  checker accepts move this cycle
- path_end  input  1  producer has no further moves (solver done/fail)
- mem_rd  output  1  maze memory read strobe
- mem_addr  output  2W  {y, x} of the cell being probed
- mem_dout  input  1  read data, valid the cycle after mem_rd; 1 = wall
- busy  output  1  high in every state except IDLE, DONE and FAIL
- done  output  1  goal reached; held until start or reset
- fail  output  1  path rejected; held until start or reset
- err_code  output  2  00 none, 01 out of range, 10 wall, 11 path ended before goal
- x_o  output  W  current column
- y_o  output  W  current row
- step_cnt  output  STEP_W  number of accepted legal moves

Behaviour:
- Reset (rst low, asynchronous): state IDLE; x, y, step_cnt = 0; done, fail, move_ready and mem_rd = 0; err_code = 00; mem_addr = 0.
- States: IDLE, WAIT, CALC, PROBE, CHECK, DONE, FAIL.
- IDLE/DONE/FAIL + start: clear x, y, step_cnt, done, fail and err_code; go to WAIT.
- WAIT: move_ready = 1.
  - move_valid = 1: register move; go to CALC.
  - Else path_end = 1: go to FAIL, err_code 11.
  - move_valid and path_end together: the move wins; path_end is re-sampled on the next WAIT visit.
- CALC:
  - Compute nx, ny at W+1 bits.
  - x = 0 with left, y = 0 with up, or an all-ones coordinate incremented: go to FAIL, err_code 01; x and y are unchanged.
  - Else register nx, ny; go to PROBE.
- PROBE: mem_rd = 1; mem_addr = {ny, nx}; go to CHECK.
- CHECK: sample mem_dout.
  - mem_dout = 1: go to FAIL, err_code 10; x and y are unchanged.
  - mem_dout = 0: commit x = nx, y = ny; step_cnt increments, saturating at 2^STEP_W-1.
  - Committed cell equals (GOAL_X, GOAL_Y): go to DONE. Else go to WAIT.
- DONE: done = 1. FAIL: fail = 1. Both hold until start or reset; move_ready = 0 in both.
- Throughput: one move per 4 cycles. move_ready re-asserts 3 cycles after the accepting edge.
- start is ignored in WAIT, CALC, PROBE and CHECK; the check in progress is unaffected.
- Revisiting cells is legal; no loop detection.
- mem_rd is 0 and mem_addr holds its last value outside PROBE.
- Reset mid-operation aborts immediately to the reset values; no partial commit.
- x_o, y_o and step_cnt reflect committed state only; they remain readable in DONE and FAIL.

Decomposition:
- Shared package maze_pkg holds:
  - move encodings MV_UP, MV_RIGHT, MV_LEFT, MV_DOWN (the solver uses the same ones);
  - error codes ERR_NONE, ERR_RANGE, ERR_WALL, ERR_END;
  - the state enumeration.
- One sub-module, maze_coord_step: combinational; (x, y, move) -> (nx, ny, out_of_range). Reusable by the solver datapath.
- FSM and registers stay in maze_path_checker.

Test Plan:
- Open 16x16 maze. Start; send 15 right then 15 down, producer waits for move_ready each time -> done = 1 after the 30th CHECK; step_cnt = 30; x_o = y_o = 15; err_code 00; each move takes 4 cycles.
- Start at (0,0); send move 00 (up) -> fail = 1 in the CALC cycle; err_code 01; mem_rd never asserted; x_o = y_o = 0; step_cnt = 0.
- Wall at {y=0, x=2}. Send right, right -> second PROBE drives mem_addr = 0x02; fail with err_code 10; x_o = 1; step_cnt = 1.
- Send 3 legal moves, then hold move_valid low with path_end = 1 in WAIT -> fail, err_code 11, step_cnt = 3. Repeat with move_valid and path_end high together -> the move is accepted first.
- Mid-move: pull rst low during PROBE -> all outputs return to reset values asynchronously. Separately, pulse start during CALC -> no effect.
- After DONE, pulse start -> done drops next cycle; x, y and step_cnt clear; move_ready = 1 again.
